fl_arb: RTL and testbench
=========================

Name: fl_arb

Overview:
- Round-robin arbiter that shares the single-ported block free list between NUM_PORTS ingress allocators and NUM_PORTS egress freers.
- Drives the free list's alloc/free interface and routes the returned block index back to the winning port.
- Keeps a shadow count of free blocks, so an alloc is issued only when the free list is guaranteed to grant it.
- Flags protocol violations such as a double free or a missing grant.

Parameters:
- NUM_PORTS, 4, number of requesting ports; applies to the alloc side and to the free side.
- ADDR_W, mem_pkg::ADDR_W, block index width.
- NUM_BLOCKS, mem_pkg::NUM_BLOCKS, total blocks held by the free list.
- LOW_WM, 8, low-watermark threshold on available blocks.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req_i  in  NUM_PORTS  per-port alloc request; level, held until ack
- alloc_ack_o  out  NUM_PORTS  one-hot pulse; the alloc for that port is done
- alloc_idx_o  out  ADDR_W  allocated block index; valid only in the alloc_ack_o cycle
- free_valid_i  in  NUM_PORTS  per-port free request; level, held until ready
- free_idx_i  in  NUM_PORTS*ADDR_W  packed free indices; port p at [p*ADDR_W +: ADDR_W]
- free_ready_o  out  NUM_PORTS  one-hot pulse; that port's free was accepted this cycle
- fl_alloc_req_o  out  1  to free list alloc_req_i
- fl_alloc_gnt_i  in  1  from free list alloc_gnt_o
- fl_alloc_idx_i  in  ADDR_W  from free list alloc_block_idx_o
- fl_free_req_o  out  1  to free list free_req_i
- fl_free_idx_o  out  ADDR_W  to free list free_block_idx_i
- avail_cnt_o  out  ADDR_W+1  shadow count of free blocks
- low_o  out  1  avail_cnt_o < LOW_WM
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - avail_cnt = NUM_BLOCKS.
  - Both round-robin pointers = 0.
  - pend mask = 0; pend_vld = 0.
  - All outputs 0, except avail_cnt_o = NUM_BLOCKS and low_o = (NUM_BLOCKS < LOW_WM).
  - err_o = 0.
- Free side, evaluated every cycle, combinational issue:
  - The winner is the first p with free_valid_i[p], scanning from free_ptr upward with wrap.
  - In the same cycle: fl_free_req_o = 1, fl_free_idx_o = free_idx_i[winner], free_ready_o[winner] = 1.
  - free_ptr <= winner+1 mod NUM_PORTS.
  - Double-free guard: if avail_cnt == NUM_BLOCKS and no alloc is issued this cycle, assert free_ready_o[winner] (consume), hold fl_free_req_o = 0, and set err_o.
- Alloc side, combinational issue:
  - Eligible set = alloc_req_i & ~pend.
  - Issue only if (avail_cnt > 0 or a free is issued this cycle).
  - The winner is chosen round-robin from alloc_ptr.
  - On issue: fl_alloc_req_o = 1; pend[winner] <= 1; pend_port <= winner; pend_vld <= 1; alloc_ptr <= winner+1 mod NUM_PORTS.
  - One alloc may be issued per cycle (pipelined); the free list grants with 1-cycle latency.
- Grant return:
  - If pend_vld in cycle t+1: expect fl_alloc_gnt_i = 1.
  - Drive alloc_ack_o[pend_port] = 1 and alloc_idx_o = fl_alloc_idx_i (combinational pass-through).
  - Clear pend[pend_port]. pend_vld <= issue-this-cycle.
  - Missing grant while pend_vld: set err_o, clear pend[pend_port], no ack; the port retries.
  - Grant while !pend_vld: set err_o and ignore the grant.
- Pend mask: stops a port whose req is still high in the ack cycle from being allocated twice. The pend bit is cleared in the ack cycle; the port is eligible again from the next cycle.
- Count update, same cycle as issue:
  - alloc only: avail_cnt - 1.
  - free only: avail_cnt + 1.
  - both: unchanged (the free list bypasses the freed index to the alloc).
  - Never wraps; width ADDR_W+1.
- Simultaneous alloc and free issue at avail_cnt == 0: legal. The alloc is granted the index being freed.
- Reset mid-operation: an outstanding alloc is discarded with no ack. The free list shares rst_n and restores all blocks, so the shadow count stays consistent.
- err_o is cleared only by reset.
- Combinational paths exist from alloc_req_i/free_valid_i to fl_* outputs. No combinational path exists from fl_alloc_gnt_i to fl_alloc_req_o.

Test Plan:
1. After reset, alloc_req_i = 4'b1111 held -> fl_alloc_req_o high 4 consecutive cycles; acks one-hot in order ports 0,1,2,3 in cycles 2..5; alloc_idx_o = NUM_BLOCKS, NUM_BLOCKS-1, NUM_BLOCKS-2, NUM_BLOCKS-3; avail_cnt_o = NUM_BLOCKS-4.
2. Port 2 holds alloc_req_i through its ack cycle -> exactly one ack per request; a second alloc for port 2 is issued only after its ack, never in the ack cycle.
3. Drain to avail_cnt_o = 0 with requests pending -> fl_alloc_req_o stays 0. Then free_valid_i[1] with idx 5 -> same-cycle alloc+free; next cycle ack with alloc_idx_o = 5; avail_cnt_o stays 0.
4. free_valid_i = 4'b1011 held, one index each -> free_ready_o pulses ports 0,1,3 in consecutive cycles; avail_cnt_o increments by 1 per cycle.
5. At avail_cnt_o = NUM_BLOCKS, issue a free with no alloc -> free_ready_o pulses, fl_free_req_o = 0, err_o = 1 and stays high until reset.
6. Hold fl_alloc_gnt_i = 0 for one grant cycle -> err_o = 1, no ack, port re-arbitrates. Assert rst_n = 0 mid-burst -> all outputs at reset values; avail_cnt_o = NUM_BLOCKS.

Source files
------------

// File: rtl/fl_arb_if.sv
// Bundle of signals between the free-list arbiter, its requesting ports and
// the single-ported block free list.
interface fl_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 5
);
  // Requesting-port side
  logic [NUM_PORTS-1:0]        alloc_req_i;
  logic [NUM_PORTS-1:0]        alloc_ack_o;
  logic [ADDR_W-1:0]           alloc_idx_o;
  logic [NUM_PORTS-1:0]        free_valid_i;
  logic [NUM_PORTS*ADDR_W-1:0] free_idx_i;
  logic [NUM_PORTS-1:0]        free_ready_o;
  // Free-list side
  logic                        fl_alloc_req_o;
  logic                        fl_alloc_gnt_i;
  logic [ADDR_W-1:0]           fl_alloc_idx_i;
  logic                        fl_free_req_o;
  logic [ADDR_W-1:0]           fl_free_idx_o;
  // Status
  logic [ADDR_W:0]             avail_cnt_o;
  logic                        low_o;
  logic                        err_o;

  // Arbiter view
  modport slave (
    input  alloc_req_i, free_valid_i, free_idx_i, fl_alloc_gnt_i, fl_alloc_idx_i,
    output alloc_ack_o, alloc_idx_o, free_ready_o, fl_alloc_req_o, fl_free_req_o,
           fl_free_idx_o, avail_cnt_o, low_o, err_o
  );

  // Environment view (ports plus free list)
  modport master (
    output alloc_req_i, free_valid_i, free_idx_i, fl_alloc_gnt_i, fl_alloc_idx_i,
    input  alloc_ack_o, alloc_idx_o, free_ready_o, fl_alloc_req_o, fl_free_req_o,
           fl_free_idx_o, avail_cnt_o, low_o, err_o
  );
endinterface

// File: rtl/fl_arb.sv
// Round-robin arbiter sharing one block free list between NUM_PORTS allocators
// and NUM_PORTS freers. A shadow count of free blocks ensures an alloc is only
// issued when the free list is certain to grant it.
module fl_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 5,
  parameter int NUM_BLOCKS = 16,
  parameter int LOW_WM     = 8
) (
  input logic    clk,
  input logic    rst_n,
  fl_arb_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef logic [NUM_PORTS-1:0] mask_t;

  logic [CNT_W-1:0] avail_cnt_reg, avail_cnt_next;
  logic [PTR_W-1:0] free_ptr_reg, free_ptr_next;
  logic [PTR_W-1:0] alloc_ptr_reg, alloc_ptr_next;
  mask_t            pend_reg, pend_next;
  logic [PTR_W-1:0] pend_port_reg, pend_port_next;
  logic             pend_vld_reg, pend_vld_next;
  logic             err_reg, err_next;

  logic [ADDR_W-1:0] free_idx_arr [NUM_PORTS];

  logic             free_any, alloc_any;
  logic [PTR_W-1:0] free_win, alloc_win;
  mask_t            alloc_elig;
  logic             cnt_full, cnt_empty;
  logic             alloc_issue, free_issue, free_guard;
  logic             grant_ok;

  // First requester at or after ptr, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input mask_t req, input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx_w;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx   = (int'(ptr) + i) % NUM_PORTS;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] win);
    return (win == PTR_W'(NUM_PORTS - 1)) ? '0 : win + PTR_W'(1);
  endfunction

  function automatic mask_t onehot(input logic [PTR_W-1:0] p);
    mask_t m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign free_idx_arr[gi] = bus.free_idx_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Issue decisions for this cycle, both sides.
  always_comb begin
    free_any   = |bus.free_valid_i;
    free_win   = rr_pick(bus.free_valid_i, free_ptr_reg);
    alloc_elig = bus.alloc_req_i & ~pend_reg;
    alloc_any  = |alloc_elig;
    alloc_win  = rr_pick(alloc_elig, alloc_ptr_reg);
    cnt_full   = (avail_cnt_reg == CNT_W'(NUM_BLOCKS));
    cnt_empty  = (avail_cnt_reg == '0);
    // At an empty count a free is never guarded, so any valid free is issued
    // and the free list bypasses that index straight to the alloc.
    alloc_issue = alloc_any && (!cnt_empty || free_any);
    // Free while every block is already free: consume it but keep it away
    // from the free list, which would otherwise hold a duplicate.
    free_guard  = free_any && cnt_full && !alloc_issue;
    free_issue  = free_any && !free_guard;
    grant_ok    = pend_vld_reg && bus.fl_alloc_gnt_i;
  end

  assign bus.fl_alloc_req_o = alloc_issue;
  assign bus.fl_free_req_o  = free_issue;
  assign bus.fl_free_idx_o  = free_issue ? free_idx_arr[free_win] : '0;
  assign bus.free_ready_o   = free_any ? onehot(free_win) : '0;
  assign bus.alloc_ack_o    = grant_ok ? onehot(pend_port_reg) : '0;
  assign bus.alloc_idx_o    = grant_ok ? bus.fl_alloc_idx_i : '0;
  assign bus.avail_cnt_o    = avail_cnt_reg;
  assign bus.low_o          = (avail_cnt_reg < CNT_W'(LOW_WM));
  assign bus.err_o          = err_reg;

  // Next-state: pointers, pending mask, shadow count and sticky error.
  always_comb begin
    avail_cnt_next = avail_cnt_reg;
    free_ptr_next  = free_ptr_reg;
    alloc_ptr_next = alloc_ptr_reg;
    pend_next      = pend_reg;
    pend_port_next = pend_port_reg;
    pend_vld_next  = alloc_issue;
    err_next       = err_reg;

    if (free_any) begin
      free_ptr_next = rr_next(free_win);
    end
    // Outstanding alloc resolves this cycle, granted or not.
    if (pend_vld_reg) begin
      pend_next = pend_next & ~onehot(pend_port_reg);
    end
    if (alloc_issue) begin
      pend_next      = pend_next | onehot(alloc_win);
      pend_port_next = alloc_win;
      alloc_ptr_next = rr_next(alloc_win);
    end

    case ({alloc_issue, free_issue})
      2'b10:   avail_cnt_next = avail_cnt_reg - CNT_W'(1);
      2'b01:   avail_cnt_next = avail_cnt_reg + CNT_W'(1);
      default: avail_cnt_next = avail_cnt_reg;
    endcase

    if (free_guard || (pend_vld_reg && !bus.fl_alloc_gnt_i) ||
        (!pend_vld_reg && bus.fl_alloc_gnt_i)) begin
      err_next = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_cnt_reg <= CNT_W'(NUM_BLOCKS);
      free_ptr_reg  <= '0;
      alloc_ptr_reg <= '0;
      pend_reg      <= '0;
      pend_port_reg <= '0;
      pend_vld_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      avail_cnt_reg <= avail_cnt_next;
      free_ptr_reg  <= free_ptr_next;
      alloc_ptr_reg <= alloc_ptr_next;
      pend_reg      <= pend_next;
      pend_port_reg <= pend_port_next;
      pend_vld_reg  <= pend_vld_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_fl_arb.sv
// Randomised bench for fl_arb: requesting ports and a stack-based free list
// are emulated here, and every cycle the DUT outputs are compared with a
// behavioural model of the arbitration rules.
module tb_fl_arb;
  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int NB  = 16;
  localparam int LWM = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fl_arb_if #(.NUM_PORTS(N), .ADDR_W(AW)) bus ();

  fl_arb #(.NUM_PORTS(N), .ADDR_W(AW), .NUM_BLOCKS(NB), .LOW_WM(LWM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Port clients
  int want [N];
  int fq   [N][$];
  int held [$];
  // Free-list emulation
  int fl_stack [$];
  bit env_gnt_pend;
  int env_gnt_idx;
  bit drop_once;
  bit drv_gnt;
  int drv_aidx;
  // Reference model state
  int m_cnt, m_fptr, m_aptr, m_pend_port;
  bit m_pend [N];
  bit m_pend_vld, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [N-1:0]    ar, fv;
    logic [N*AW-1:0] fi;
    ar = '0; fv = '0; fi = '0;
    for (int p = 0; p < N; p++) begin
      ar[p] = (want[p] > 0);
      fv[p] = (fq[p].size() > 0);
      if (fv[p]) fi[p*AW +: AW] = AW'(fq[p][0]);
    end
    drv_gnt  = 1'b0;
    drv_aidx = 0;
    if (env_gnt_pend) begin
      if (drop_once) begin
        drop_once = 1'b0;
        fl_stack.push_back(env_gnt_idx);
      end else begin
        drv_gnt  = 1'b1;
        drv_aidx = env_gnt_idx;
      end
    end
    bus.alloc_req_i    = ar;
    bus.free_valid_i   = fv;
    bus.free_idx_i     = fi;
    bus.fl_alloc_gnt_i = drv_gnt;
    bus.fl_alloc_idx_i = AW'(drv_aidx);
  endtask

  task automatic step();
    int p, fwin, awin, exp_ready, exp_ack, exp_aidx, exp_fidx;
    bit favail, aany, a_issue, f_issue, guard, gnt;
    logic [N-1:0] fv, ar, ack, rdy;
    @(negedge clk);
    cyc++;
    drive_inputs();
    #1;
    fv = bus.free_valid_i; ar = bus.alloc_req_i; gnt = drv_gnt;
    favail = 0; fwin = 0;
    for (int i = 0; i < N; i++) begin
      p = (m_fptr + i) % N;
      if (!favail && fv[p]) begin favail = 1; fwin = p; end
    end
    aany = 0; awin = 0;
    for (int i = 0; i < N; i++) begin
      p = (m_aptr + i) % N;
      if (!aany && ar[p] && !m_pend[p]) begin aany = 1; awin = p; end
    end
    a_issue   = aany && (m_cnt > 0 || favail);
    guard     = favail && (m_cnt == NB) && !a_issue;
    f_issue   = favail && !guard;
    exp_ready = favail ? (1 << fwin) : 0;
    exp_fidx  = f_issue ? fq[fwin][0] : 0;
    exp_ack   = (m_pend_vld && gnt) ? (1 << m_pend_port) : 0;
    exp_aidx  = (m_pend_vld && gnt) ? drv_aidx : 0;

    check("fl_alloc_req", 32'(bus.fl_alloc_req_o), 32'(a_issue));
    check("fl_free_req",  32'(bus.fl_free_req_o),  32'(f_issue));
    check("fl_free_idx",  32'(bus.fl_free_idx_o),  exp_fidx);
    check("free_ready",   32'(bus.free_ready_o),   exp_ready);
    check("alloc_ack",    32'(bus.alloc_ack_o),    exp_ack);
    check("alloc_idx",    32'(bus.alloc_idx_o),    exp_aidx);
    check("avail_cnt",    32'(bus.avail_cnt_o),    m_cnt);
    check("low",          32'(bus.low_o),          32'(m_cnt < LWM));
    check("err",          32'(bus.err_o),          32'(m_err));

    // Model advance
    m_err = m_err | guard | (m_pend_vld && !gnt) | (!m_pend_vld && gnt);
    m_cnt = m_cnt + (f_issue ? 1 : 0) - (a_issue ? 1 : 0);
    if (favail) m_fptr = (fwin + 1) % N;
    if (m_pend_vld) m_pend[m_pend_port] = 0;
    if (a_issue) begin
      m_pend[awin] = 1;
      m_pend_port  = awin;
      m_aptr       = (awin + 1) % N;
    end
    m_pend_vld = a_issue;

    // Clients react to what the DUT reported
    ack = bus.alloc_ack_o;
    rdy = bus.free_ready_o;
    for (int q = 0; q < N; q++) begin
      if (ack[q]) begin
        if (want[q] > 0) want[q]--;
        held.push_back(int'(bus.alloc_idx_o));
        $display("[TB] cyc %0d alloc ack port %0d idx %0d", cyc, q, bus.alloc_idx_o);
      end
      if (rdy[q] && fq[q].size() > 0) begin
        $display("[TB] cyc %0d free accepted port %0d idx %0d", cyc, q, fq[q][0]);
        void'(fq[q].pop_front());
      end
    end
    // Free list reacts to the requests it saw
    if (bus.fl_alloc_req_o) begin
      env_gnt_pend = 1'b1;
      if (bus.fl_free_req_o)        env_gnt_idx = int'(bus.fl_free_idx_o);
      else if (fl_stack.size() > 0) env_gnt_idx = fl_stack.pop_back();
      else                          env_gnt_idx = 0;
    end else begin
      env_gnt_pend = 1'b0;
      if (bus.fl_free_req_o) fl_stack.push_back(int'(bus.fl_free_idx_o));
    end
  endtask

  task automatic apply_reset();
    #2;
    rst_n              = 1'b0;
    bus.alloc_req_i    = '0;
    bus.free_valid_i   = '0;
    bus.free_idx_i     = '0;
    bus.fl_alloc_gnt_i = 1'b0;
    bus.fl_alloc_idx_i = '0;
    #1;
    check("rst_alloc_ack",    32'(bus.alloc_ack_o),    0);
    check("rst_alloc_idx",    32'(bus.alloc_idx_o),    0);
    check("rst_free_ready",   32'(bus.free_ready_o),   0);
    check("rst_fl_alloc_req", 32'(bus.fl_alloc_req_o), 0);
    check("rst_fl_free_req",  32'(bus.fl_free_req_o),  0);
    check("rst_fl_free_idx",  32'(bus.fl_free_idx_o),  0);
    check("rst_avail_cnt",    32'(bus.avail_cnt_o),    NB);
    check("rst_low",          32'(bus.low_o),          32'(NB < LWM));
    check("rst_err",          32'(bus.err_o),          0);
    m_cnt = NB; m_fptr = 0; m_aptr = 0; m_pend_port = 0;
    m_pend_vld = 0; m_err = 0;
    for (int p = 0; p < N; p++) begin
      m_pend[p] = 0;
      want[p]   = 0;
      fq[p].delete();
    end
    held.delete();
    fl_stack.delete();
    for (int b = 1; b <= NB; b++) fl_stack.push_back(b);
    env_gnt_pend = 1'b0;
    drop_once    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ports3 [3];
    int k, v;
    ports3 = '{0, 1, 3};
    apply_reset();

    // All four ports request once: issued back to back, acked in port order.
    for (int p = 0; p < N; p++) want[p] = 1;
    repeat (8) step();
    check("t1_cnt", 32'(bus.avail_cnt_o), NB - 4);
    for (int i = 0; i < 4; i++) check("t1_idx_order", held[i], NB - i);

    // Port 2 keeps its request high across the ack: two separate allocs.
    want[2] = 2;
    repeat (8) step();
    check("t2_cnt", 32'(bus.avail_cnt_o), NB - 6);

    // Drain the list with requests still waiting, then free index 5.
    for (int p = 0; p < N; p++) want[p] = 3;
    repeat (30) step();
    check("t3_drained", 32'(bus.avail_cnt_o), 0);
    for (int i = held.size() - 1; i >= 0; i--) if (held[i] == 5) held.delete(i);
    fq[1].push_back(5);
    repeat (2) step();
    check("t3_bypass_idx", held[held.size() - 1], 5);
    check("t3_cnt_zero", 32'(bus.avail_cnt_o), 0);

    // Free everything back through ports 0, 1 and 3.
    k = 0;
    repeat (40) begin
      while (held.size() > 0) begin
        v = held.pop_front();
        fq[ports3[k % 3]].push_back(v);
        k++;
      end
      step();
    end
    check("t4_full", 32'(bus.avail_cnt_o), NB);

    // Free with every block already free: consumed, error latched.
    fq[2].push_back(3);
    repeat (2) step();
    check("t5_err", 32'(bus.err_o), 1);
    repeat (3) step();
    check("t5_err_sticky", 32'(bus.err_o), 1);
    apply_reset();

    // Missing grant, then reset in the middle of a burst.
    drop_once = 1'b1;
    want[0] = 1; want[1] = 1;
    repeat (4) step();
    check("t6_err", 32'(bus.err_o), 1);
    for (int p = 0; p < N; p++) want[p] = 2;
    repeat (3) step();
    apply_reset();
    repeat (2) step();

    // Random traffic.
    repeat (500) begin
      if ($urandom_range(0, 3) == 0 &&
          (want[0] + want[1] + want[2] + want[3]) < 6)
        want[$urandom_range(0, N - 1)]++;
      if (held.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, held.size() - 1);
        fq[$urandom_range(0, N - 1)].push_back(held[k]);
        held.delete(k);
      end
      step();
    end
    // Drain: stop requesting, return every held block.
    for (int p = 0; p < N; p++) want[p] = 0;
    repeat (150) begin
      while (held.size() > 0) fq[$urandom_range(0, N - 1)].push_back(held.pop_front());
      step();
    end
    check("final_full", 32'(bus.avail_cnt_o), NB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
